// File: rtl/zle_par.sv
// Parametrised zero run-length encoder with a registered single-entry output slot.
// Optional end-of-stream flush enabled by defining ZLE_PAR_EOS_EN (adds i_e/o_e).
module zle_par #(
    parameter int  DW     = 3,
    parameter int  MAXRUN = 8,
    localparam int CW     = $clog2(MAXRUN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_d,
    input  logic          i_v,
`ifdef ZLE_PAR_EOS_EN
    input  logic          i_e,
    output logic          o_e,
`endif
    output logic          i_b,
    output logic [DW:0]   o_d,
    output logic          o_v,
    input  logic          o_b
);

    typedef enum logic [1:0] {IDLE, ZEROS, LIT} state_e;

    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] MAXC = CW'(MAXRUN);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] lit_q, lit_d;
    logic          o_v_q, o_v_d;
    logic [DW:0]   o_d_q, o_d_d;

    logic          slot_free, acc, nz, eos, full;
    logic [CW-1:0] cnt_inc, cnt_m1;
    logic          ld;
    logic [DW:0]   ld_tok;

`ifdef ZLE_PAR_EOS_EN
    assign eos = i_e;
`else
    assign eos = 1'b0;
`endif

    assign slot_free = ~o_v_q | ~o_b;
    assign i_b       = (state_q == LIT) | (o_v_q & o_b);
    assign acc       = i_v & ~i_b;
    assign nz        = |i_d;
    assign cnt_inc   = cnt_q + ONE;
    assign cnt_m1    = cnt_q - ONE;
    assign full      = (cnt_inc == MAXC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lit_q   <= '0;
            o_v_q   <= 1'b0;
            o_d_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lit_q   <= lit_d;
            o_v_q   <= o_v_d;
            o_d_q   <= o_d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lit_d   = lit_q;
        unique case (state_q)
            IDLE: begin
                if (acc && !nz && !eos && MAXRUN > 1) begin
                    cnt_d   = ONE;
                    state_d = ZEROS;
                end
            end
            ZEROS: begin
                if (acc) begin
                    if (nz) begin
                        lit_d   = i_d;
                        cnt_d   = '0;
                        state_d = LIT;
                    end else if (eos || full) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            LIT: begin
                if (slot_free) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld     = 1'b0;
        ld_tok = '0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (nz) begin
                        ld     = 1'b1;
                        ld_tok = {1'b0, i_d};
                    end else if (eos || MAXRUN == 1) begin
                        ld     = 1'b1;
                        ld_tok = {1'b1, {DW{1'b0}}};
                    end
                end
            end
            ZEROS: begin
                if (acc) begin
                    if (nz) begin
                        ld     = 1'b1;
                        ld_tok = {1'b1, DW'(cnt_m1)};
                    end else if (eos) begin
                        // the terminating zero is part of the run
                        ld     = 1'b1;
                        ld_tok = {1'b1, DW'(cnt_q)};
                    end else if (full) begin
                        ld     = 1'b1;
                        ld_tok = {1'b1, DW'(MAXRUN - 1)};
                    end
                end
            end
            LIT: begin
                if (slot_free) begin
                    ld     = 1'b1;
                    ld_tok = {1'b0, lit_q};
                end
            end
            default: ;
        endcase
    end

    // slot holds while stalled; a load may replace a token consumed this cycle
    assign o_v_d = ld | (o_v_q & o_b);
    assign o_d_d = ld ? ld_tok : o_d_q;
    assign o_v   = o_v_q;
    assign o_d   = o_d_q;

`ifdef ZLE_PAR_EOS_EN
    logic lit_e_q, o_e_q, ld_e;

    assign ld_e = (state_q == LIT) ? lit_e_q
                : (acc & eos & ~((state_q == ZEROS) & nz));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit_e_q <= 1'b0;
            o_e_q   <= 1'b0;
        end else begin
            if (state_q == ZEROS && acc && nz) lit_e_q <= eos;
            if (ld) o_e_q <= ld_e;
        end
    end

    assign o_e = o_e_q;
`endif

endmodule

// File: tb/tb_zle_par.sv
// Self-checking bench for zle_par: vector table, corner sequences,
// randomized stream against a token-level reference model.
module tb_zle_par;

    localparam int MR0 = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] id = '0, id1 = '0;
    logic       iv = 1'b0, iv1 = 1'b0;
    logic       ie = 1'b0, ie1 = 1'b0;
    logic       ob = 1'b0, ob1 = 1'b0;
    logic       ib, ib1;
    logic [3:0] od, od1;
    logic       ov, ov1;
    logic       oe, oe1;

    int total = 0;
    int bad = 0;
    bit rnd_ob = 0;

    logic [4:0] got_q[$];
    logic [4:0] got1_q[$];
    logic [4:0] exp_q[$];
    logic [2:0] stim[$];

    always #5 clk = ~clk;

    zle_par #(.DW(3), .MAXRUN(MR0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_d(id), .i_v(iv),
`ifdef ZLE_PAR_EOS_EN
        .i_e(ie), .o_e(oe),
`endif
        .i_b(ib), .o_d(od), .o_v(ov), .o_b(ob)
    );

    zle_par #(.DW(3), .MAXRUN(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_d(id1), .i_v(iv1),
`ifdef ZLE_PAR_EOS_EN
        .i_e(ie1), .o_e(oe1),
`endif
        .i_b(ib1), .o_d(od1), .o_v(ov1), .o_b(ob1)
    );

`ifndef ZLE_PAR_EOS_EN
    assign oe  = 1'b0;
    assign oe1 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, a, e);
        end
    endtask

    // output monitor plus hold-stability check while stalled
    logic       prev_hold = 1'b0;
    logic [4:0] prev_tok = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if (!(ov === 1'b1 && {oe, od} === prev_tok)) begin
                    bad++;
                    $display("FAIL hold got=%0h/%0b exp=%0h/1", {oe, od}, ov, prev_tok);
                end
            end
            if (ov && !ob) got_q.push_back({oe, od});
            prev_hold = ov & ob;
            prev_tok  = {oe, od};
            if (ov1 && !ob1) got1_q.push_back({oe1, od1});
        end
    end

    task automatic feed(input logic [2:0] t, input logic e);
        int  n = 0;
        bit  done = 0;
        iv = 1'b1; id = t; ie = e;
        while (!done) begin
            @(negedge clk);
            if (!ib) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                total++; bad++;
                $display("FAIL feed_timeout got=blocked exp=accept");
                done = 1;
            end
        end
        iv = 1'b0; ie = 1'b0;
    endtask

    task automatic feed1(input logic [2:0] t);
        int  n = 0;
        bit  done = 0;
        iv1 = 1'b1; id1 = t;
        while (!done) begin
            @(negedge clk);
            if (!ib1) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 200) begin
                total++; bad++;
                $display("FAIL feed1_timeout got=blocked exp=accept");
                done = 1;
            end
        end
        iv1 = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string nm);
        chk({nm, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // token-level reference: count zeros, flush at MAXRUN or before a literal
    task automatic model();
        int run = 0;
        exp_q.delete();
        foreach (stim[i]) begin
            if (stim[i] == 3'd0) begin
                run++;
                if (run == MR0) begin
                    exp_q.push_back({2'b01, 3'(MR0 - 1)});
                    run = 0;
                end
            end else begin
                if (run > 0) exp_q.push_back({2'b01, 3'(run - 1)});
                run = 0;
                exp_q.push_back({2'b00, stim[i]});
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain(1);
        got_q.delete();
        got1_q.delete();
    endtask

    typedef struct {
        int          nin;
        logic [59:0] din;
        int          nout;
        logic [31:0] dout;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{5,  {45'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd5}, 3, {20'd0, 4'h3, 4'hA, 4'h5}};
        vt[1] = '{18, 60'd1 << 51,                           4, {16'd0, 4'h1, 4'h8, 4'hF, 4'hF}};
        vt[2] = '{3,  {51'd0, 3'd3, 3'd2, 3'd1},             3, {20'd0, 4'h3, 4'h2, 4'h1}};
        vt[3] = '{2,  {54'd0, 3'd7, 3'd0},                   2, {24'd0, 4'h7, 4'h8}};
        vt[4] = '{9,  60'd4 << 24,                           2, {24'd0, 4'h4, 4'hF}};
        vt[5] = '{8,  60'd1 << 21,                           2, {24'd0, 4'h1, 4'hE}};

        #1;
        chk("rst_ov", ov, 1'b0);
        chk("rst_od", od, 4'h0);
        chk("rst_ib", ib, 1'b0);
        chk("rst_ov1", ov1, 1'b0);
        do_reset();
        chk("post_rst_ib", ib, 1'b0);
        chk("post_rst_ov", ov, 1'b0);

        foreach (vt[v]) begin
            for (int i = 0; i < vt[v].nin; i++)
                feed(vt[v].din[i*3 +: 3], 1'b0);
            drain(4);
            for (int i = 0; i < vt[v].nout; i++)
                exp_q.push_back({1'b0, vt[v].dout[i*4 +: 4]});
            cmp_q($sformatf("vec%0d", v));
        end

        // back-pressure lasts exactly one cycle in LIT
        feed(3'd0, 1'b0);
        feed(3'd0, 1'b0);
        feed(3'd3, 1'b0);
        @(negedge clk);
        chk("lit_ib_hi", ib, 1'b1);
        @(negedge clk);
        chk("lit_ib_lo", ib, 1'b0);
        drain(3);
        exp_q.push_back(5'h09);
        exp_q.push_back(5'h03);
        cmp_q("lit_seq");

        // stall with a literal in the slot
        ob = 1'b1;
        feed(3'd5, 1'b0);
        iv = 1'b1; id = 3'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("stall_ov%0d", c), ov, 1'b1);
            chk($sformatf("stall_od%0d", c), od, 4'h5);
            chk($sformatf("stall_ib%0d", c), ib, 1'b1);
        end
        @(posedge clk); #1;
        ob = 1'b0;
        feed(3'd0, 1'b0);
        feed(3'd0, 1'b0);
        feed(3'd2, 1'b0);
        drain(4);
        exp_q.push_back(5'h05);
        exp_q.push_back(5'h09);
        exp_q.push_back(5'h02);
        cmp_q("stall_seq");

        // single-zero runs
        feed1(3'd0);
        feed1(3'd0);
        feed1(3'd2);
        drain(4);
        got_q = got1_q;
        got1_q.delete();
        exp_q.push_back(5'h08);
        exp_q.push_back(5'h08);
        exp_q.push_back(5'h02);
        cmp_q("mr1_seq");

        // reset while three zeros are pending
        feed(3'd0, 1'b0);
        feed(3'd0, 1'b0);
        feed(3'd0, 1'b0);
        drain(3);
        chk("idle_no_run", got_q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ov", ov, 1'b0);
        chk("rst_mid_ib", ib, 1'b0);
        do_reset();
        feed(3'd6, 1'b0);
        drain(4);
        exp_q.push_back(5'h06);
        cmp_q("after_rst");

        // reset drops a token held in a stalled slot
        ob = 1'b1;
        feed(3'd4, 1'b0);
        @(negedge clk);
        chk("slot_full_ov", ov, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_slot_ov", ov, 1'b0);
        chk("rst_slot_od", od, 4'h0);
        ob = 1'b0;
        do_reset();
        drain(3);
        chk("rst_slot_lost", got_q.size(), 0);

`ifdef ZLE_PAR_EOS_EN
        feed(3'd0, 1'b0);
        feed(3'd0, 1'b0);
        feed(3'd4, 1'b1);
        drain(4);
        exp_q.push_back(5'h09);
        exp_q.push_back(5'h14);
        cmp_q("eos_lit");
        feed(3'd0, 1'b0);
        feed(3'd0, 1'b1);
        drain(4);
        exp_q.push_back(5'h19);
        cmp_q("eos_run");
        feed(3'd0, 1'b1);
        feed(3'd7, 1'b1);
        drain(4);
        exp_q.push_back(5'h18);
        exp_q.push_back(5'h17);
        cmp_q("eos_idle");
`endif

        // randomized stream with random back-pressure and input gaps
        stim.delete();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] t;
            t = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if (i == 399) t = 3'($urandom_range(1, 7));
            stim.push_back(t);
        end
        rnd_ob = 1;
        foreach (stim[i]) begin
            if ($urandom_range(0, 3) == 0) drain(1);
            feed(stim[i], 1'b0);
        end
        rnd_ob = 0;
        ob = 1'b0;
        drain(10);
        model();
        cmp_q("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ob) ob = ($urandom_range(0, 9) < 3);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zle_par.md
# zle_par

Parametrised zero run-length encoder: the successor to the fixed 3-bit/4-bit ZLE, with generic token width and maximum run length, plus optional end-of-stream (EOS) flush. It sits between two valid/back-pressure streams. Non-zero tokens pass through as literals; runs of zero tokens are compressed into a single run token. FSM and datapath live in one module with a registered single-entry output slot.

## Interface
- DW, 3, input token width; output token width is DW+1
- MAXRUN, 8, longest run per run token; legal range 1..2^DW
- CW, $clog2(MAXRUN+1), run counter width (derived, not overridden)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_d  in  DW  input token
- i_v  in  1  input valid
- i_b  out  1  input back-pressure; transfer when i_v=1 and i_b=0
- i_e  in  1  end-of-stream marker, qualified by i_v (only with ZLE_PAR_EOS_EN)
- o_d  out  DW+1  output token: {0,lit} literal, {1,n-1} run of n zeros
- o_v  out  1  output valid (registered)
- o_b  in  1  output back-pressure; transfer when o_v=1 and o_b=0
- o_e  out  1  marks the final token of a stream (only with ZLE_PAR_EOS_EN)

## Operation
- States: IDLE (no run pending), ZEROS (cnt zeros pending, 1..MAXRUN-1), LIT (run token emitted, literal held in lit_q awaiting the slot).
- slot_free = ~o_v | ~o_b. Loading the slot sets o_v=1 and o_d. Consuming the slot with no load clears o_v.
- i_b = (state==LIT) | (o_v & o_b). It is a function of registered state and o_b only, never of i_d or i_v.
- IDLE, accept nonzero x: load {0,x}, stay IDLE.
- IDLE, accept zero: if MAXRUN=1, load {1,0}; otherwise cnt=1 and go to ZEROS.
- ZEROS, accept zero: cnt+1. On reaching MAXRUN, load {1,MAXRUN-1}, cnt=0, go to IDLE.
- ZEROS, accept nonzero x: load {1,cnt-1}, lit_q=x, go to LIT.
- LIT: when slot_free, load {0,lit_q} and go to IDLE.
- Count arithmetic is unsigned CW bits. cnt never exceeds MAXRUN-1 while in ZEROS.
- A pending run is emitted only on a nonzero input, on reaching MAXRUN, or on EOS. It is never emitted on idle time.

## Timing
- Reset values: o_v=0, o_d=0, o_e=0, state=IDLE, cnt=0, lit_q=0. i_b=0 after reset.
- Reset asserted mid-run or in LIT discards the pending count and literal. No token is emitted.
- Latency: a literal accepted in IDLE appears on o_d the next cycle. A run token appears the cycle after the accept of the terminating token.
- A nonzero after a run costs 2 output cycles. i_b is high for at least 1 cycle in LIT.
- Simultaneous consume and load in the same cycle is legal: o_v stays 1 and o_d is replaced. Full throughput is 1 token/cycle when o_b=0.
- o_d, o_v and o_e are held stable while o_v=1 and o_b=1.

## Configuration
- ZLE_PAR_EOS_EN defined: ports i_e and o_e exist.
  - Accepted token with i_e=1 flushes the encoder, which returns to IDLE with cnt=0.
  - Zero with i_e=1 in IDLE or ZEROS: load a run token {1,cnt} counting this zero, with o_e=1.
  - Nonzero with i_e=1 in IDLE: literal with o_e=1.
  - Nonzero with i_e=1 in ZEROS: run token with o_e=0, then literal from LIT with o_e=1. lit_e is held alongside lit_q.
- ZLE_PAR_EOS_EN undefined: i_e and o_e ports are absent. A trailing run stays pending until the next nonzero or until it reaches MAXRUN.

## Test plan
- DW=3, MAXRUN=8, o_b=0. Input 5,0,0,0,3 -> output {0,5},{1,2},{0,3}. i_b high exactly 1 cycle after the 3 is accepted.
- 17 consecutive zeros then 1 -> output {1,7},{1,7},{1,0},{0,1}.
- Stall: o_b=1 for 4 cycles holding {0,5}. Inputs are blocked (i_b=1) and o_d stays stable. Release -> remaining tokens follow in order with none lost.
- MAXRUN=1: input 0,0,2 -> output {1,0},{1,0},{0,2}.
- ZLE_PAR_EOS_EN: input 0,0,4 with i_e on the 4 -> {1,1} o_e=0, then {0,4} o_e=1. Input 0,0 with i_e on the 2nd zero -> {1,1} o_e=1.
- Drop reset low while in ZEROS with cnt=3 -> o_v=0 immediately, no run token ever emitted. Next input 6 -> {0,6}.
